md_sched: RTL and testbench
===========================

# md_sched

Multiply/divide scheduler for the five-stage MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo operations from the EX stage, computes the result at issue, and holds HI/LO back for a fixed busy latency. It raises a stall request toward the decode stage while an operation is pending. Issue is cancelled or aborted when the pipeline is flushed for an exception, so HI/LO never reflect an operation from a squashed instruction.

## Interface
Parameters:
- MULT_CYCLES, default 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, default 10, busy cycles for div/divu (>=1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- op_valid  in  1  EX-stage operation present this cycle
- op  in  3  0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo; 6,7 = no-op
- rs  in  32  operand A (dividend / mthi-mtlo source)
- rt  in  32  operand B (divisor)
- flush  in  1  exception/eret flush; cancels same-cycle issue and aborts in-flight op
- md_use_d  in  1  decode-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- busy  out  1  operation in flight (registered)
- stall_req  out  1  combinational: md_use_d & (busy | (op_valid & op<=3 & ~flush))
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, RUN. 5-bit down-counter cnt, pending registers hi_p/lo_p.
- IDLE, op_valid=1, flush=0, op in 0..3: compute into hi_p/lo_p, load cnt with MULT_CYCLES or DIV_CYCLES, go RUN.
- IDLE, op_valid=1, flush=0, op=4: hi<=rs at edge. op=5: lo<=rs. No busy.
- RUN: cnt decrements each edge. At the edge where cnt==1: hi<=hi_p, lo<=lo_p, go IDLE.
- RUN with flush=1: go IDLE at next edge, hi/lo unchanged, pending discarded.
- op_valid while RUN: ignored (protocol violation; stall_req prevents it). The bench flags it with an assertion.
- Arithmetic:
  - mult: {hi,lo} = signed 64-bit product.
  - multu: unsigned 64-bit product.
  - div: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - divu: unsigned quotient and remainder.
  - Divisor 0 (div/divu): full DIV_CYCLES busy; hi/lo keep their prior values at commit.
- op 6/7 with op_valid: no effect.

## Timing
- Reset (async, low): state=IDLE, cnt=0, busy=0, hi=0, lo=0, hi_p=lo_p=0. stall_req then follows md_use_d & op_valid issue term only.
- Issue sampled at edge T0:
  - busy=1 for cycles T0+1 .. T0+N (N = MULT_CYCLES or DIV_CYCLES).
  - New hi/lo are visible from edge T0+N onward, i.e. in the first cycle busy=0.
  - Back-to-back issue is legal in the cycle busy falls.
- mthi/mtlo: hi/lo update at the issuing edge, visible next cycle. Zero latency penalty.
- stall_req is asserted in the issue cycle itself, so a dependent mfhi/mflo in decode is held before busy rises.
- flush and issue in the same cycle: issue discarded; state stays IDLE; stall_req is not raised by the issue term.
- flush during RUN at edge Tk: busy=0 from Tk; hi/lo never updated.
- reset deasserted mid-RUN is impossible by definition (reset clears RUN). reset asserted mid-RUN: busy drops asynchronously, hi=lo=0.
- flush with no op in flight: no effect.

## Test plan
- Signed mult: rs=0xFFFFFFFE (-2), rt=0x00000003, op=0 at T0 -> busy high 5 cycles; at T0+5 hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- Signed div: rs=0xFFFFFFF9 (-7), rt=2, op=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; overflow case 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: preload hi=0x11, lo=0x22 via mthi/mtlo; divu rs=5, rt=0 -> busy 10 cycles, hi=0x11, lo=0x22 after.
- Flush: issue mult at T0, flush=1 at T0+2 -> busy=0 from T0+3, hi/lo unchanged. Separately, issue with flush=1 in the same cycle -> busy never rises.
- Stall: md_use_d=1 throughout a div issue -> stall_req=1 for the issue cycle plus 10 busy cycles, 0 in the first cycle after busy falls; md_use_d=0 -> stall_req=0 throughout.
- Async reset: assert reset low mid-RUN between clock edges -> busy, hi, lo go to 0 without waiting for a clock edge; the first op after release behaves normally.

Source files
------------

// File: rtl/md_sched.sv
// md_sched: MIPS mult/div scheduler with fixed busy latency.
// Results are computed at issue and committed to HI/LO when busy falls.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        flush,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

  logic [0:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_p_q, hi_p_d;
  logic [31:0] lo_p_q, lo_p_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_safe;
  logic [31:0] q_mag, r_mag, quo, rem;
  logic        sgn, neg_q, neg_r;
  logic        issue, is_md;

  // Multiply/divide datapath; signed divide works on magnitudes
  // so the most-negative / -1 case needs no special handling.
  always_comb begin
    prod_s = 64'($signed({{32{rs[31]}}, rs}) *
                 $signed({{32{rt[31]}}, rt}));
    prod_u = {32'b0, rs} * {32'b0, rt};
    sgn    = (op == 3'd2);
    a_mag  = (sgn && rs[31]) ? (32'd0 - rs) : rs;
    b_mag  = (sgn && rt[31]) ? (32'd0 - rt) : rt;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    neg_q  = sgn & (rs[31] ^ rt[31]);
    neg_r  = sgn & rs[31];
    quo    = neg_q ? (32'd0 - q_mag) : q_mag;
    rem    = neg_r ? (32'd0 - r_mag) : r_mag;
  end

  assign issue = op_valid & ~flush & (state_q == S_IDLE);
  assign is_md = ~op[2];

  // Next-state: issue, countdown, commit and flush abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_p_d  = hi_p_q;
    lo_p_d  = lo_p_q;
    unique case (state_q)
      S_IDLE: begin
        if (issue) begin
          unique case (1'b1)
            (op == 3'd0): begin
              hi_p_d  = prod_s[63:32];
              lo_p_d  = prod_s[31:0];
              cnt_d   = MULT_N;
              state_d = S_RUN;
            end
            (op == 3'd1): begin
              hi_p_d  = prod_u[63:32];
              lo_p_d  = prod_u[31:0];
              cnt_d   = MULT_N;
              state_d = S_RUN;
            end
            (op == 3'd2),
            (op == 3'd3): begin
              hi_p_d  = (rt == 32'd0) ? hi_q : rem;
              lo_p_d  = (rt == 32'd0) ? lo_q : quo;
              cnt_d   = DIV_N;
              state_d = S_RUN;
            end
            (op == 3'd4): hi_d = rs;
            (op == 3'd5): lo_d = rs;
            default: ;
          endcase
        end
      end
      default: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = 5'd0;
          hi_p_d  = 32'd0;
          lo_p_d  = 32'd0;
        end else begin
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            hi_d    = hi_p_q;
            lo_d    = lo_p_q;
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hi_p_q  <= 32'd0;
      lo_p_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_p_q  <= hi_p_d;
      lo_p_q  <= lo_p_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign stall_req = md_use_d &
                     (busy | (op_valid & is_md & ~flush));
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed checks of md_sched latency, arithmetic,
// flush, stall and async reset behaviour.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd6;
  logic [31:0] rs = 32'd0;
  logic [31:0] rt = 32'd0;
  logic        flush = 1'b0;
  logic        md_use_d = 1'b0;
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  int vec = 0;
  int err = 0;

  md_sched dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .rs(rs), .rt(rt), .flush(flush), .md_use_d(md_use_d),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Protocol check: no issue attempt while an op is in flight.
  always @(posedge clk) begin
    if (reset && busy && op_valid) begin
      err++;
      $error("FAIL op_valid_in_run: got 1, want 0");
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    op_valid = 1'b1;
    op = o;
    rs = a;
    rt = b;
    @(negedge clk);
    op_valid = 1'b0;
    op = 3'd6;
  endtask

  task automatic run_out(input string tag, input int exp_n);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy"}, 32'(n), 32'(exp_n));
  endtask

  initial begin
    int n;
    int s;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    md_use_d = 1'b1;
    op_valid = 1'b1;
    op = 3'd0;
    #1;
    chk("rst_stall", 32'(stall_req), 32'd1);
    op_valid = 1'b0;
    op = 3'd6;
    md_use_d = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    issue(3'd0, 32'hFFFFFFFE, 32'h3);
    chk("mult_hold_hi", hi, 32'd0);
    run_out("mult", 5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);

    issue(3'd1, 32'hFFFFFFFE, 32'h3);
    run_out("multu", 5);
    chk("multu_hi", hi, 32'h2);
    chk("multu_lo", lo, 32'hFFFFFFFA);

    issue(3'd2, 32'hFFFFFFF9, 32'h2);
    run_out("div", 10);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    run_out("divovf", 10);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'h0);

    issue(3'd3, 32'd100, 32'd7);
    run_out("divu", 10);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    issue(3'd4, 32'h11, 32'h0);
    chk("mthi_hi", hi, 32'h11);
    chk("mthi_busy", 32'(busy), 32'd0);
    issue(3'd5, 32'h22, 32'h0);
    chk("mtlo_lo", lo, 32'h22);
    chk("mtlo_hi", hi, 32'h11);

    issue(3'd3, 32'd5, 32'd0);
    run_out("div0", 10);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);

    issue(3'd7, 32'h55, 32'h66);
    chk("nop_busy", 32'(busy), 32'd0);
    chk("nop_hi", hi, 32'h11);

    issue(3'd0, 32'd3, 32'd4);
    chk("fl_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_busy0", 32'(busy), 32'd0);
    repeat (6) @(negedge clk);
    chk("fl_hi", hi, 32'h11);
    chk("fl_lo", lo, 32'h22);

    md_use_d = 1'b1;
    flush = 1'b1;
    op_valid = 1'b1;
    op = 3'd0;
    rs = 32'd9;
    rt = 32'd9;
    #1;
    chk("flsame_stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    op_valid = 1'b0;
    flush = 1'b0;
    op = 3'd6;
    chk("flsame_busy", 32'(busy), 32'd0);
    repeat (6) @(negedge clk);
    chk("flsame_lo", lo, 32'h22);

    op_valid = 1'b1;
    op = 3'd3;
    rs = 32'd9;
    rt = 32'd3;
    #1;
    chk("st_issue", 32'(stall_req), 32'd1);
    @(negedge clk);
    op_valid = 1'b0;
    op = 3'd6;
    n = 0;
    while (stall_req === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("st_cycles", 32'(n), 32'd10);
    chk("st_after", 32'(stall_req), 32'd0);
    chk("st_busy", 32'(busy), 32'd0);
    chk("st_lo", lo, 32'd3);
    chk("st_hi", hi, 32'd0);

    md_use_d = 1'b0;
    op_valid = 1'b1;
    op = 3'd0;
    rs = 32'd2;
    rt = 32'd2;
    #1;
    chk("nost_issue", 32'(stall_req), 32'd0);
    @(negedge clk);
    op_valid = 1'b0;
    op = 3'd6;
    n = 0;
    s = 0;
    while (busy === 1'b1 && n < 40) begin
      if (stall_req) s++;
      n++;
      @(negedge clk);
    end
    chk("nost_count", 32'(s), 32'd0);
    chk("nost_busy", 32'(n), 32'd5);
    chk("nost_lo", lo, 32'd4);

    issue(3'd0, 32'd7, 32'd7);
    @(negedge clk);
    chk("ar_busy1", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_hi", hi, 32'd0);
    chk("ar_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(3'd0, 32'd7, 32'd6);
    run_out("post", 5);
    chk("post_lo", lo, 32'd42);
    chk("post_hi", hi, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
